// File: rtl/uart_matmul_core_if.sv
// Byte-stream bundle between the UART receiver/transmitter and the matmul core.
// Latency: none; wires only.
// Backpressure: the tx side uses a start/busy handshake; the rx side cannot be stalled.
interface uart_matmul_core_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    // Environment side: the receiver drives rx_*, the transmitter drives tx_busy.
    modport master (
        output rx_valid, rx_data, rx_err, tx_busy,
        input  tx_start, tx_data
    );

    // Core side.
    modport slave (
        input  rx_valid, rx_data, rx_err, tx_busy,
        output tx_start, tx_data
    );
endinterface

// File: rtl/uart_matmul_core.sv
// Collects A and B (DIM x DIM, u8, row-major) from rx bytes, computes C = A*B with one MAC per clk, sends C MSB-first.
// Latency: DIM^3+2 clk from the last rx byte to the first tx_start; one tx byte in flight at a time.
// Backpressure: tx_start is held until tx_busy is seen; rx bytes arriving while busy are dropped and set ovf.
// Build option: define UART_MATMUL_SAT_EN to saturate each C element to 0xFFFF; otherwise it wraps to 16 bits.
module uart_matmul_core #(
    parameter int DIM = 2,
    parameter int CW  = 18
) (
    input  logic              clk,
    input  logic              rst,
    uart_matmul_core_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [7:0]        led
);

    localparam int         N         = DIM * DIM;
    localparam int         AW        = (N > 1) ? $clog2(N) : 1;
    localparam int         IW        = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [4:0] LAST_SLOT = 5'(2 * N - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIM - 1);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_MAC    = 3'd1,
        S_SEND   = 3'd2,
        S_ACCEPT = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;        // rx slot while loading, tx byte index while sending
    logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [CW-1:0] acc_q, acc_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;

    logic [7:0]    a_mem [N];
    logic [7:0]    b_mem [N];
    logic [15:0]   c_mem [N];

    logic          ld_we;
    logic          c_we;
    logic [AW-1:0] a_waddr, b_waddr;
    logic [AW-1:0] a_raddr, b_raddr, c_addr, c_raddr;
    logic [15:0]   prod;
    logic [CW-1:0] sum;
    logic [15:0]   c_red;
    logic [15:0]   c_rd;
    logic [7:0]    send_byte;

    // Address and datapath arithmetic shared by the FSM and the storage.
    always_comb begin
        a_waddr   = AW'(cnt_q);
        b_waddr   = AW'(cnt_q - 5'(N));
        a_raddr   = AW'(32'(i_q) * DIM + 32'(k_q));
        b_raddr   = AW'(32'(k_q) * DIM + 32'(j_q));
        c_addr    = AW'(32'(i_q) * DIM + 32'(j_q));
        c_raddr   = AW'(cnt_q >> 1);
        prod      = 16'(a_mem[a_raddr]) * 16'(b_mem[b_raddr]);
        sum       = acc_q + CW'(prod);
        c_rd      = c_mem[c_raddr];
        send_byte = cnt_q[0] ? c_rd[7:0] : c_rd[15:8];
    end

`ifdef UART_MATMUL_SAT_EN
    // Clamp sums that do not fit in 16 bits.
    always_comb begin
        c_red = (sum > CW'(32'h0000_FFFF)) ? 16'hFFFF : sum[15:0];
    end
`else
    // Keep the low 16 bits; overflow wraps.
    always_comb begin
        c_red = sum[15:0];
    end
`endif

    // Next-state and output decode; rx_err beats rx_valid when both arrive together.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        acc_d      = acc_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        ld_we      = 1'b0;
        c_we       = 1'b0;

        if (state_q != S_LOAD && bus.rx_valid) begin
            ovf_d = 1'b1;
        end

        unique case (state_q)
            S_LOAD: begin
                if (bus.rx_err) begin
                    cnt_d = 5'd0;
                end else if (bus.rx_valid) begin
                    ld_we = 1'b1;
                    if (cnt_q == LAST_SLOT) begin
                        cnt_d   = 5'd0;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = S_MAC;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_MAC: begin
                if (k_q == LAST_IDX) begin
                    c_we  = 1'b1;
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q == LAST_IDX) begin
                        j_d = '0;
                        if (i_q == LAST_IDX) begin
                            i_d     = '0;
                            cnt_d   = 5'd0;
                            state_d = S_SEND;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    acc_d = sum;
                    k_d   = k_q + 1'b1;
                end
            end
            S_SEND: begin
                tx_data_d  = send_byte;
                tx_start_d = 1'b1;
                state_d    = S_ACCEPT;
            end
            S_ACCEPT: begin
                if (bus.tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!bus.tx_busy) begin
                    if (cnt_q < LAST_SLOT) begin
                        cnt_d   = cnt_q + 5'd1;
                        state_d = S_SEND;
                    end else begin
                        done_d  = 1'b1;
                        cnt_d   = 5'd0;
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            cnt_q      <= 5'd0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    // Matrix storage; contents are only meaningful once fully written, so no reset.
    always_ff @(posedge clk) begin
        if (ld_we && cnt_q < 5'(N)) begin
            a_mem[a_waddr] <= bus.rx_data;
        end
        if (ld_we && cnt_q >= 5'(N)) begin
            b_mem[b_waddr] <= bus.rx_data;
        end
        if (c_we) begin
            c_mem[c_addr] <= c_red;
        end
    end

    // Output mapping; busy follows the state so reset clears it immediately.
    always_comb begin
        bus.tx_start = tx_start_q;
        bus.tx_data  = tx_data_q;
        busy         = (state_q != S_LOAD);
        done         = done_q;
        ovf          = ovf_q;
        led          = {3'(state_q), cnt_q};
    end

endmodule

// File: tb/tb_uart_matmul_core.sv
// Directed bench for uart_matmul_core with DIM=2: loads A/B, models the transmitter, checks result bytes and flags.
// Latency: transmitter model raises tx_busy a few clk after tx_start (500 clk for the first byte of the slow case).
// Backpressure: the model holds tx_busy high for a programmable time; stalls are checked for stable tx_start/tx_data.
module tb_uart_matmul_core;

    logic       clk;
    logic       rst;
    logic       busy;
    logic       done;
    logic       ovf;
    logic [7:0] led;

    uart_matmul_core_if bus_if();

    uart_matmul_core #(.DIM(2), .CW(18)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .busy (busy),
        .done (done),
        .ovf  (ovf),
        .led  (led)
    );

    int         n_chk      = 0;
    int         n_fail     = 0;
    int         done_cnt   = 0;
    int         viol       = 0;
    bit         slow_first = 1'b0;
    logic [7:0] tx_q [$];
    logic [7:0] exp_b [8];

    localparam logic [63:0] RAMP     = 64'h0102_0304_0506_0708;
    localparam logic [63:0] ALL_FF   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] RAMP_RES = 64'h0013_0016_002B_0032;
`ifdef UART_MATMUL_SAT_EN
    localparam logic [63:0] FF_RES   = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    localparam logic [63:0] FF_RES   = 64'hFC02_FC02_FC02_FC02;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Transmitter model: accepts tx_start, raises tx_busy after lat clk, holds it hold clk.
    initial begin
        bus_if.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus_if.tx_start === 1'b1 && !bus_if.tx_busy) begin : accept
                logic [7:0] cap;
                int         lat;
                int         hold;
                cap  = bus_if.tx_data;
                lat  = (slow_first && tx_q.size() == 0) ? 500 : 2;
                hold = (slow_first && tx_q.size() == 0) ? 10000 : 3;
                tx_q.push_back(cap);
                repeat (lat) begin
                    @(negedge clk);
                    if (!rst && (bus_if.tx_start !== 1'b1 || bus_if.tx_data !== cap)) viol++;
                end
                bus_if.tx_busy = 1'b1;
                repeat (hold) begin
                    @(negedge clk);
                    if (!rst && bus_if.tx_start !== 1'b0) viol++;
                end
                bus_if.tx_busy = 1'b0;
            end
        end
    end

    // Count done pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic load8(input logic [63:0] v);
        for (int i = 0; i < 8; i++) send_byte(v[63 - 8 * i -: 8]);
    endtask

    task automatic start_case(input logic [63:0] res);
        tx_q.delete();
        done_cnt = 0;
        viol     = 0;
        for (int i = 0; i < 8; i++) exp_b[i] = res[63 - 8 * i -: 8];
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n;
        n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(done_cnt), 32'd1);
        repeat (5) @(negedge clk);
        chk({tag, "_once"}, 32'(done_cnt), 32'd1);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_nbytes"}, 32'(tx_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_b%0d", tag, i),
                (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hFFFF_FFFF, 32'(exp_b[i]));
        end
        chk({tag, "_hs"}, 32'(viol), 32'd0);
    endtask

    initial begin : stim
        int n;
        rst              = 1'b0;
        bus_if.rx_valid  = 1'b0;
        bus_if.rx_data   = 8'd0;
        bus_if.rx_err    = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_txs", {31'd0, bus_if.tx_start}, 32'd0);
        chk("rst_txd", 32'(bus_if.tx_data), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic ramp.
        start_case(RAMP_RES);
        load8(RAMP);
        wait_done("ramp", 500);
        chk("ramp_ovf", {31'd0, ovf}, 32'd0);
        chk("ramp_led", 32'(led), 32'd0);

        // All 0xFF: sum exceeds 16 bits.
        start_case(FF_RES);
        load8(ALL_FF);
        wait_done("ff", 500);

        // Partial load aborted by rx_err coinciding with a byte.
        start_case(RAMP_RES);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        chk("err_cnt3", 32'(led), 32'd3);
        @(negedge clk);
        bus_if.rx_err   = 1'b1;
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h99;
        @(negedge clk);
        bus_if.rx_err   = 1'b0;
        bus_if.rx_valid = 1'b0;
        chk("err_cnt0", 32'(led), 32'd0);
        chk("err_ovf", {31'd0, ovf}, 32'd0);
        load8(RAMP);
        wait_done("err", 500);

        // Slow transmitter on the first byte.
        start_case(RAMP_RES);
        slow_first = 1'b1;
        load8(RAMP);
        wait_done("slow", 20000);
        slow_first = 1'b0;

        // Bytes arriving during MAC and DRAIN.
        start_case(RAMP_RES);
        load8(RAMP);
        chk("ovf_in_mac", 32'(led[7:5]), 32'd1);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h55;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        chk("ovf_mac", {31'd0, ovf}, 32'd1);
        n = 0;
        while (led[7:5] != 3'd4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ovf_in_drain", 32'(led[7:5]), 32'd4);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h55;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        chk("ovf_drain", {31'd0, ovf}, 32'd1);
        wait_done("ovf", 500);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);

        // Reset during the third result byte.
        start_case(RAMP_RES);
        load8(RAMP);
        n = 0;
        while (tx_q.size() < 3 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid_seen", 32'(tx_q.size()), 32'd3);
        chk("mid_txs_before", {31'd0, bus_if.tx_start}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_txs", {31'd0, bus_if.tx_start}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        chk("mid_ovf", {31'd0, ovf}, 32'd0);
        start_case(RAMP_RES);
        load8(RAMP);
        wait_done("after_rst", 500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_matmul_core.md
Name: uart_matmul_core

Overview:
- Downstream compute stage between the UART byte receiver and the UART byte transmitter in the matrix-multiplication datapath.
- Collects two DIM×DIM unsigned 8-bit matrices A and B from the rx byte stream, both in row-major order.
- Computes C = A·B with one sequential multiply-accumulate (MAC) per cycle.
- Streams each C element to the transmitter as two bytes, MSB first, in row-major order.

Parameters:
- DIM, 2, matrix dimension; legal range 1..4.
- CW, 18, accumulator width; must be ≥ 16+clog2(DIM).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- rx_valid  in  1  one-clk pulse per received byte (edge-detected receiver done).
- rx_data  in  8  received byte; valid while rx_valid=1.
- rx_err  in  1  one-clk pulse on receiver framing error.
- tx_start  out  1  request to transmitter; held high until the byte is accepted.
- tx_data  out  8  byte to send; stable while tx_start=1.
- tx_busy  in  1  transmitter busy level.
- busy  out  1  high in every state except S_LOAD.
- done  out  1  one-clk pulse after the last result byte is accepted.
- ovf  out  1  sticky: an rx byte arrived while busy; cleared only by rst.
- led  out  8  {state[2:0], byte/element counter[4:0]}.

Behaviour:
- Reset (async, immediate): state=S_LOAD, counters=0, tx_start=0, tx_data=0, busy=0, done=0, ovf=0, led=0. A/B/C storage need not clear.
- S_LOAD
  - Each rx_valid writes rx_data to slot cnt: cnt 0..N-1 → A, cnt N..2N-1 → B, where N=DIM*DIM; then cnt++.
  - The cycle that writes slot 2N-1 → S_MAC.
  - rx_err in S_LOAD → cnt=0; A/B discarded.
  - rx_err and rx_valid in the same cycle: error wins, byte dropped.
- S_MAC
  - Indices i, j, k; acc = acc + A[i][k]*B[k][j] (8×8 product zero-extended to CW), one term per cycle.
  - At k=DIM-1: C[i][j] = final sum; acc cleared; advance j, then i.
  - Total DIM³ cycles, then → S_SEND with byte index b=0.
- Result reduction: CW bits → 16 bits; see Optional Feature.
- S_SEND
  - Load tx_data = (b even) ? C[b/2][15:8] : C[b/2][7:0]; set tx_start=1 → S_ACCEPT.
- S_ACCEPT
  - Hold tx_start=1 and tx_data until tx_busy=1 is sampled; then tx_start=0 → S_DRAIN.
- S_DRAIN
  - Wait for tx_busy=0.
  - If b<2N-1: b++ → S_SEND.
  - Else: done=1 for one cycle, cnt=0 → S_LOAD.
- Throughput of a tx_busy level that never rises: the block stalls in S_ACCEPT indefinitely; no timeout.
- rx_valid in any state other than S_LOAD: byte ignored, ovf←1.
- rx_err outside S_LOAD: ignored.
- Minimum latency from last input byte to first tx_start: DIM³+2 clk.
- Reset asserted mid-send deasserts tx_start asynchronously; a partial frame on the line is the transmitter's concern.

Optional Feature:
- Macro: UART_MATMUL_SAT_EN.
- Defined: each C value > 0xFFFF is stored as 0xFFFF (saturation).
- Undefined: each C value is stored as sum[15:0] (wrap-around).

Test Plan:
- DIM=2; rx bytes 01 02 03 04 05 06 07 08 → tx sequence 00 13 00 16 00 2B 00 32; one done pulse; ovf=0.
- All eight bytes = FF; sum = 0x1FC02 → with UART_MATMUL_SAT_EN tx FF FF ×4, without it tx FC 02 ×4.
- Send 3 bytes, pulse rx_err, then send full vector 01..08 → same result as the first scenario (earlier bytes discarded).
- Inject rx_valid (byte 0x55) during S_MAC and during S_DRAIN → ovf=1 and stays 1; result bytes unchanged.
- Transmitter model raises tx_busy 500 clk after tx_start and holds it 10000 clk → tx_start stays high until tx_busy=1, tx_data stable throughout, next byte only after tx_busy=0; 8 bytes total.
- Assert rst during the 3rd result byte → tx_start=0 and busy=0 in the same cycle; a following 01..08 load produces a correct full result.
